div_iter: RTL

//  Multi-cycle iterative restoring divider, signed or unsigned per operation, for the EX-stage DIV/DIVU path.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 20 ++
 rtl/div_iter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared divider definitions: FSM state encoding and result-ready constants.
package div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_t;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   partial,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem,
   output logic         qbit
);

   logic [W+1:0] diff;

   // The extra top bit of diff is the borrow: clear means partial >= divisor, so keep the difference.
   always_comb begin
      diff = {1'b0, partial} - {2'b00, divisor};
      qbit = ~diff[W+1];
      rem  = qbit ? diff[W-1:0] : partial[W-1:0];
   end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned per operation.
module div_iter
   import div_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic           annul_i,
   input  logic           signed_i,
   input  logic [W-1:0]   opdata1_i,
   input  logic [W-1:0]   opdata2_i,
   output logic [2*W-1:0] result_o,
   output logic           ready_o,
   output logic           busy_o,
   output logic           div_by_zero_o
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

   div_state_t     state;
   div_state_t     next_state;
   logic [CNT_W-1:0] counter;
   logic [W-1:0]   dividend;
   logic [W-1:0]   divisor;
   logic [W-1:0]   rem;
   logic [W-1:0]   quot;
   logic           quot_neg;
   logic           rem_neg;
   logic [2*W-1:0] result;
   logic           by_zero;

   logic           op1_neg;
   logic           op2_neg;
   logic [W-1:0]   op1_mag;
   logic [W-1:0]   op2_mag;
   logic [W-1:0]   step_rem;
   logic           step_qbit;
   logic [W-1:0]   quot_full;
   logic [W-1:0]   quot_fixed;
   logic [W-1:0]   rem_fixed;

   div_step #(.W(W)) u_step (
      .partial (({rem, dividend[W-1]})),
      .divisor (divisor),
      .rem     (step_rem),
      .qbit    (step_qbit)
   );

   // Operand magnitudes (only in signed mode) and the sign-corrected final result of the last step.
   always_comb begin
      op1_neg    = signed_i & opdata1_i[W-1];
      op2_neg    = signed_i & opdata2_i[W-1];
      op1_mag    = op1_neg ? (~opdata1_i + W'(1)) : opdata1_i;
      op2_mag    = op2_neg ? (~opdata2_i + W'(1)) : opdata2_i;
      quot_full  = {quot[W-2:0], step_qbit};
      quot_fixed = quot_neg ? (~quot_full + W'(1)) : quot_full;
      rem_fixed  = rem_neg ? (~step_rem + W'(1)) : step_rem;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DIV_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; annul overrides every other transition, including completion.
   always_comb begin
      next_state = state;
      if (annul_i) begin
         next_state = DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i) begin
                  next_state = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
               end
            end
            DIV_BYZERO: next_state = DIV_END;
            DIV_ON: begin
               if (counter == LAST_STEP) begin
                  next_state = DIV_END;
               end
            end
            DIV_END: begin
               if (!start_i) begin
                  next_state = DIV_IDLE;
               end
            end
            default: next_state = DIV_IDLE;
         endcase
      end
   end

   // Datapath: latch operands on accept, iterate in ON, hold the result in END, clear on leaving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter  <= '0;
         dividend <= '0;
         divisor  <= '0;
         rem      <= '0;
         quot     <= '0;
         quot_neg <= 1'b0;
         rem_neg  <= 1'b0;
         result   <= '0;
         by_zero  <= 1'b0;
      end else if (annul_i) begin
         counter <= '0;
         result  <= '0;
         by_zero <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i) begin
                  dividend <= op1_mag;
                  divisor  <= op2_mag;
                  quot_neg <= op1_neg ^ op2_neg;
                  rem_neg  <= op1_neg;
                  rem      <= '0;
                  quot     <= '0;
                  counter  <= '0;
                  result   <= '0;
                  by_zero  <= 1'b0;
               end
            end
            DIV_BYZERO: begin
               result  <= '0;
               by_zero <= 1'b1;
            end
            DIV_ON: begin
               dividend <= {dividend[W-2:0], 1'b0};
               rem      <= step_rem;
               quot     <= quot_full;
               counter  <= counter + CNT_W'(1);
               if (counter == LAST_STEP) begin
                  result <= {rem_fixed, quot_fixed};
               end
            end
            DIV_END: begin
               if (!start_i) begin
                  result  <= '0;
                  by_zero <= 1'b0;
               end
            end
            default: begin
               result  <= '0;
               by_zero <= 1'b0;
            end
         endcase
      end
   end

   // Outputs decoded from state and the held result registers.
   always_comb begin
      ready_o       = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      busy_o        = (state == DIV_BYZERO) || (state == DIV_ON);
      result_o      = result;
      div_by_zero_o = by_zero;
   end

endmodule
